// File: rtl/hms_bcd_counter.sv
// Hours/minutes/seconds BCD time-of-day counter on the 1 Hz SEC_CLK, with a
// validated parallel load, registered carry pulses and a fixed-length alarm.
module hms_bcd_counter #(
    parameter int ALARM_LEN = 60,
    parameter int ALM_W     = 8
) (
    input  logic       SEC_CLK,
    input  logic       CLR,
    input  logic       RUN,
    input  logic       LOAD,
    input  logic [1:0] LD_HOUR_10,
    input  logic [3:0] LD_HOUR_01,
    input  logic [2:0] LD_MIN_10,
    input  logic [3:0] LD_MIN_01,
    input  logic       ALM_EN,
    input  logic [1:0] ALM_HOUR_10,
    input  logic [3:0] ALM_HOUR_01,
    input  logic [2:0] ALM_MIN_10,
    input  logic [3:0] ALM_MIN_01,
    output logic [3:0] SEC_01,
    output logic [2:0] SEC_10,
    output logic [3:0] MIN_01,
    output logic [2:0] MIN_10,
    output logic [3:0] HOUR_01,
    output logic [1:0] HOUR_10,
    output logic       MIN_TICK,
    output logic       HOUR_TICK,
    output logic       DAY_TICK,
    output logic       LOAD_ERR,
    output logic       ALARM
);

    logic [3:0]       sec_01_r, min_01_r, hour_01_r;
    logic [2:0]       sec_10_r, min_10_r;
    logic [1:0]       hour_10_r;
    logic             min_tick_r, hour_tick_r, day_tick_r, load_err_r, alarm_r;
    logic [ALM_W-1:0] alm_cnt_r;

    logic [3:0] nxt_sec_01_s, nxt_min_01_s, nxt_hour_01_s;
    logic [2:0] nxt_sec_10_s, nxt_min_10_s;
    logic [1:0] nxt_hour_10_s;
    logic       sec_wrap_s, min_wrap_s, hour_wrap_s, inc_s, load_ok_s, alarm_hit_s;

    function automatic logic load_valid(input logic [1:0] h10, input logic [3:0] h1,
                                        input logic [2:0] m10, input logic [3:0] m1);
        return (m10 <= 3'd5) && (m1 <= 4'd9) && (h1 <= 4'd9) &&
               ((h10 < 2'd2) || ((h10 == 2'd2) && (h1 <= 4'd3)));
    endfunction

    assign inc_s       = RUN && !LOAD;
    assign load_ok_s   = load_valid(LD_HOUR_10, LD_HOUR_01, LD_MIN_10, LD_MIN_01);
    assign sec_wrap_s  = (sec_10_r == 3'd5) && (sec_01_r == 4'd9);
    assign min_wrap_s  = (min_10_r == 3'd5) && (min_01_r == 4'd9);
    assign hour_wrap_s = (hour_10_r == 2'd2) && (hour_01_r == 4'd3);

    // BCD ripple increment of the current time
    always_comb begin
        nxt_sec_01_s  = sec_01_r;
        nxt_sec_10_s  = sec_10_r;
        nxt_min_01_s  = min_01_r;
        nxt_min_10_s  = min_10_r;
        nxt_hour_01_s = hour_01_r;
        nxt_hour_10_s = hour_10_r;
        if (sec_01_r != 4'd9) begin
            nxt_sec_01_s = sec_01_r + 4'd1;
        end else begin
            nxt_sec_01_s = 4'd0;
            if (sec_10_r != 3'd5) begin
                nxt_sec_10_s = sec_10_r + 3'd1;
            end else begin
                nxt_sec_10_s = 3'd0;
                if (min_01_r != 4'd9) begin
                    nxt_min_01_s = min_01_r + 4'd1;
                end else begin
                    nxt_min_01_s = 4'd0;
                    if (min_10_r != 3'd5) begin
                        nxt_min_10_s = min_10_r + 3'd1;
                    end else begin
                        nxt_min_10_s = 3'd0;
                        if (hour_wrap_s) begin
                            nxt_hour_01_s = 4'd0;
                            nxt_hour_10_s = 2'd0;
                        end else if (hour_01_r == 4'd9) begin
                            nxt_hour_01_s = 4'd0;
                            nxt_hour_10_s = hour_10_r + 2'd1;
                        end else begin
                            nxt_hour_01_s = hour_01_r + 4'd1;
                        end
                    end
                end
            end
        end
    end

    // Alarm matches only on the increment that lands on HH:MM:00
    assign alarm_hit_s = ALM_EN && inc_s && sec_wrap_s &&
                         (nxt_hour_10_s == ALM_HOUR_10) && (nxt_hour_01_s == ALM_HOUR_01) &&
                         (nxt_min_10_s == ALM_MIN_10) && (nxt_min_01_s == ALM_MIN_01);

    // Time digits, carry pulses and load status
    always_ff @(posedge SEC_CLK or posedge CLR) begin
        if (CLR) begin
            sec_01_r    <= 4'd0;
            sec_10_r    <= 3'd0;
            min_01_r    <= 4'd0;
            min_10_r    <= 3'd0;
            hour_01_r   <= 4'd0;
            hour_10_r   <= 2'd0;
            min_tick_r  <= 1'b0;
            hour_tick_r <= 1'b0;
            day_tick_r  <= 1'b0;
            load_err_r  <= 1'b0;
        end else if (LOAD) begin
            min_tick_r  <= 1'b0;
            hour_tick_r <= 1'b0;
            day_tick_r  <= 1'b0;
            if (load_ok_s) begin
                sec_01_r   <= 4'd0;
                sec_10_r   <= 3'd0;
                min_01_r   <= LD_MIN_01;
                min_10_r   <= LD_MIN_10;
                hour_01_r  <= LD_HOUR_01;
                hour_10_r  <= LD_HOUR_10;
                load_err_r <= 1'b0;
            end else begin
                load_err_r <= 1'b1;
            end
        end else if (RUN) begin
            sec_01_r    <= nxt_sec_01_s;
            sec_10_r    <= nxt_sec_10_s;
            min_01_r    <= nxt_min_01_s;
            min_10_r    <= nxt_min_10_s;
            hour_01_r   <= nxt_hour_01_s;
            hour_10_r   <= nxt_hour_10_s;
            min_tick_r  <= sec_wrap_s;
            hour_tick_r <= sec_wrap_s && min_wrap_s;
            day_tick_r  <= sec_wrap_s && min_wrap_s && hour_wrap_s;
            load_err_r  <= 1'b0;
        end else begin
            min_tick_r  <= 1'b0;
            hour_tick_r <= 1'b0;
            day_tick_r  <= 1'b0;
            load_err_r  <= 1'b0;
        end
    end

    // Alarm duration counter; runs on every edge regardless of RUN
    always_ff @(posedge SEC_CLK or posedge CLR) begin
        if (CLR) begin
            alarm_r   <= 1'b0;
            alm_cnt_r <= '0;
        end else if (!ALM_EN) begin
            alarm_r   <= 1'b0;
            alm_cnt_r <= '0;
        end else if (alarm_hit_s) begin
            alarm_r   <= 1'b1;
            alm_cnt_r <= ALM_W'(ALARM_LEN - 1);
        end else if (alarm_r) begin
            if (alm_cnt_r == '0) begin
                alarm_r <= 1'b0;
            end else begin
                alm_cnt_r <= alm_cnt_r - {{(ALM_W-1){1'b0}}, 1'b1};
            end
        end else begin
            alarm_r   <= 1'b0;
            alm_cnt_r <= alm_cnt_r;
        end
    end

    assign SEC_01    = sec_01_r;
    assign SEC_10    = sec_10_r;
    assign MIN_01    = min_01_r;
    assign MIN_10    = min_10_r;
    assign HOUR_01   = hour_01_r;
    assign HOUR_10   = hour_10_r;
    assign MIN_TICK  = min_tick_r;
    assign HOUR_TICK = hour_tick_r;
    assign DAY_TICK  = day_tick_r;
    assign LOAD_ERR  = load_err_r;
    assign ALARM     = alarm_r;

endmodule

// File: tb/tb_hms_bcd_counter.sv
// Directed bench for hms_bcd_counter: reset, carries, day wrap, load checks,
// alarm duration and asynchronous abort.
module tb_hms_bcd_counter;

    logic       SEC_CLK, CLR, RUN, LOAD, ALM_EN;
    logic [1:0] LD_HOUR_10, ALM_HOUR_10, HOUR_10;
    logic [3:0] LD_HOUR_01, LD_MIN_01, ALM_HOUR_01, ALM_MIN_01;
    logic [2:0] LD_MIN_10, ALM_MIN_10, SEC_10, MIN_10;
    logic [3:0] SEC_01, MIN_01, HOUR_01;
    logic       MIN_TICK, HOUR_TICK, DAY_TICK, LOAD_ERR, ALARM;

    int checks = 0;
    int errors = 0;

    hms_bcd_counter #(.ALARM_LEN(3), .ALM_W(8)) dut (
        .SEC_CLK(SEC_CLK), .CLR(CLR), .RUN(RUN), .LOAD(LOAD),
        .LD_HOUR_10(LD_HOUR_10), .LD_HOUR_01(LD_HOUR_01),
        .LD_MIN_10(LD_MIN_10), .LD_MIN_01(LD_MIN_01),
        .ALM_EN(ALM_EN), .ALM_HOUR_10(ALM_HOUR_10), .ALM_HOUR_01(ALM_HOUR_01),
        .ALM_MIN_10(ALM_MIN_10), .ALM_MIN_01(ALM_MIN_01),
        .SEC_01(SEC_01), .SEC_10(SEC_10), .MIN_01(MIN_01), .MIN_10(MIN_10),
        .HOUR_01(HOUR_01), .HOUR_10(HOUR_10),
        .MIN_TICK(MIN_TICK), .HOUR_TICK(HOUR_TICK), .DAY_TICK(DAY_TICK),
        .LOAD_ERR(LOAD_ERR), .ALARM(ALARM)
    );

    initial SEC_CLK = 1'b0;
    always #5 SEC_CLK = ~SEC_CLK;

    function automatic logic [19:0] hms(input int h10, input int h1, input int m10,
                                        input int m1, input int s10, input int s1);
        return {2'(h10), 4'(h1), 3'(m10), 4'(m1), 3'(s10), 4'(s1)};
    endfunction

    function automatic logic [19:0] now();
        return {HOUR_10, HOUR_01, MIN_10, MIN_01, SEC_10, SEC_01};
    endfunction

    task automatic checkt(input string tag, input logic [19:0] obs, input logic [19:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %05h expected %05h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic edges(input int n);
        repeat (n) @(posedge SEC_CLK);
        @(negedge SEC_CLK);
    endtask

    task automatic do_load(input int h10, input int h1, input int m10, input int m1);
        LD_HOUR_10 = 2'(h10);
        LD_HOUR_01 = 4'(h1);
        LD_MIN_10  = 3'(m10);
        LD_MIN_01  = 4'(m1);
        LOAD = 1'b1;
        edges(1);
        LOAD = 1'b0;
    endtask

    task automatic check_pulses(input string tag, input logic m, input logic h, input logic d);
        check1({tag, "_min_tick"}, MIN_TICK, m);
        check1({tag, "_hour_tick"}, HOUR_TICK, h);
        check1({tag, "_day_tick"}, DAY_TICK, d);
    endtask

    initial begin
        CLR = 1'b1; RUN = 1'b0; LOAD = 1'b0; ALM_EN = 1'b0;
        LD_HOUR_10 = 2'd0; LD_HOUR_01 = 4'd0; LD_MIN_10 = 3'd0; LD_MIN_01 = 4'd0;
        ALM_HOUR_10 = 2'd0; ALM_HOUR_01 = 4'd0; ALM_MIN_10 = 3'd0; ALM_MIN_01 = 4'd0;
        #12 CLR = 1'b0;
        @(negedge SEC_CLK);

        // Reset and hold
        checkt("reset_time", now(), hms(0,0,0,0,0,0));
        check_pulses("reset", 1'b0, 1'b0, 1'b0);
        check1("reset_load_err", LOAD_ERR, 1'b0);
        check1("reset_alarm", ALARM, 1'b0);
        edges(5);
        checkt("hold_time", now(), hms(0,0,0,0,0,0));
        check_pulses("hold", 1'b0, 1'b0, 1'b0);
        check1("hold_alarm", ALARM, 1'b0);

        // Minute carry; RUN held high through the load edge
        RUN = 1'b1;
        do_load(0,0,0,0);
        checkt("load_overrides_run", now(), hms(0,0,0,0,0,0));
        for (int i = 1; i <= 60; i++) begin
            edges(1);
            check1("minute_min_tick", MIN_TICK, i == 60);
            check1("minute_hour_tick", HOUR_TICK, 1'b0);
        end
        checkt("minute_time", now(), hms(0,0,0,1,0,0));
        edges(1);
        check1("minute_tick_one_period", MIN_TICK, 1'b0);
        checkt("minute_plus_one", now(), hms(0,0,0,1,0,1));

        // Day wrap
        do_load(2,3,5,9);
        checkt("load_2359", now(), hms(2,3,5,9,0,0));
        edges(59);
        checkt("pre_wrap_time", now(), hms(2,3,5,9,5,9));
        check_pulses("pre_wrap", 1'b0, 1'b0, 1'b0);
        edges(1);
        checkt("day_wrap_time", now(), hms(0,0,0,0,0,0));
        check_pulses("day_wrap", 1'b1, 1'b1, 1'b1);
        RUN = 1'b0;
        edges(1);
        check_pulses("post_wrap", 1'b0, 1'b0, 1'b0);
        checkt("post_wrap_hold", now(), hms(0,0,0,0,0,0));

        // Load validation at 12:34:56
        RUN = 1'b1;
        do_load(1,2,3,4);
        edges(56);
        checkt("at_123456", now(), hms(1,2,3,4,5,6));
        RUN = 1'b0;
        do_load(2,4,0,0);
        check1("ld_2400_err", LOAD_ERR, 1'b1);
        checkt("ld_2400_time", now(), hms(1,2,3,4,5,6));
        edges(1);
        check1("ld_err_one_cycle", LOAD_ERR, 1'b0);
        do_load(0,9,6,0);
        check1("ld_0960_err", LOAD_ERR, 1'b1);
        checkt("ld_0960_time", now(), hms(1,2,3,4,5,6));
        do_load(1,9,4,5);
        check1("ld_1945_err", LOAD_ERR, 1'b0);
        checkt("ld_1945_time", now(), hms(1,9,4,5,0,0));

        // Alarm at 07:30, length 3
        ALM_HOUR_10 = 2'd0; ALM_HOUR_01 = 4'd7; ALM_MIN_10 = 3'd3; ALM_MIN_01 = 4'd0;
        ALM_EN = 1'b1;
        do_load(0,7,2,9);
        RUN = 1'b1;
        edges(59);
        checkt("alarm_pre_time", now(), hms(0,7,2,9,5,9));
        check1("alarm_pre", ALARM, 1'b0);
        edges(1);
        checkt("alarm_trigger_time", now(), hms(0,7,3,0,0,0));
        check1("alarm_p1", ALARM, 1'b1);
        edges(1);
        check1("alarm_p2", ALARM, 1'b1);
        edges(1);
        check1("alarm_p3", ALARM, 1'b1);
        edges(1);
        check1("alarm_end", ALARM, 1'b0);
        RUN = 1'b0;
        do_load(0,7,3,0);
        check1("alarm_load_no_trigger", ALARM, 1'b0);
        edges(2);
        check1("alarm_load_no_trigger_later", ALARM, 1'b0);

        // Asynchronous abort mid-alarm and mid-tick
        do_load(0,7,2,9);
        RUN = 1'b1;
        edges(60);
        check1("abort_alarm_active", ALARM, 1'b1);
        check1("abort_min_tick_active", MIN_TICK, 1'b1);
        #2 CLR = 1'b1;
        #1;
        checkt("abort_time", now(), hms(0,0,0,0,0,0));
        check1("abort_alarm", ALARM, 1'b0);
        check_pulses("abort", 1'b0, 1'b0, 1'b0);
        #1 CLR = 1'b0;
        edges(1);
        checkt("first_inc_after_clr", now(), hms(0,0,0,0,0,1));
        check1("alarm_after_clr", ALARM, 1'b0);
        edges(3);
        check1("alarm_stays_low", ALARM, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
